// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one request, runs it on an external unit
// or computes it locally, then holds the result until the consumer acks.
// Optional macro ALU_TIMEOUT_EN adds a 6-bit WAIT timeout (out=DEADBEEF).
// Ports: clk, rst_n (async, low); in_valid/in_ready, a, b, ctrl request;
//   unit_start/unit_sel/unit_a/unit_b/unit_ctrl issue, unit_done/unit_out
//   return; out/out_en/err result held until out_ack.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  ctrl,
  output logic        unit_start,
  output logic [1:0]  unit_sel,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic [4:0]  unit_ctrl,
  input  logic        unit_done,
  input  logic [31:0] unit_out,
  output logic [31:0] out,
  output logic        out_en,
  output logic        err,
  input  logic        out_ack
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_SLL = 5'd2;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;

  logic [1:0]  state;
  logic        is_add;
  logic        is_sll;
  logic        is_and;
  logic        is_or;
  logic        is_xor;
  logic        is_loc;
  logic [31:0] loc_res;

`ifdef ALU_TIMEOUT_EN
  logic [5:0]  tmo_cnt;
`endif

  assign is_add = (ctrl == OP_ADD) || (ctrl == OP_SUB);
  assign is_sll = (ctrl == OP_SLL);
  assign is_and = (ctrl == OP_AND);
  assign is_or  = (ctrl == OP_OR);
  assign is_xor = (ctrl == OP_XOR);
  assign is_loc = is_and | is_or | is_xor;

  // Illegal opcodes fall to the default and yield zero.
  always_comb begin
    loc_res = '0;
    unique case (1'b1)
      is_and:  loc_res = a & b;
      is_or:   loc_res = a | b;
      is_xor:  loc_res = a ^ b;
      default: loc_res = '0;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign unit_start = (state == ISSUE);
  assign out_en     = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      unit_sel  <= 2'd0;
      unit_a    <= '0;
      unit_b    <= '0;
      unit_ctrl <= '0;
      out       <= '0;
      err       <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_add || is_sll) begin
              unit_a    <= a;
              unit_b    <= is_sll ? {27'b0, b[4:0]} : b;
              unit_ctrl <= ctrl;
              unit_sel  <= is_sll ? 2'd1 : 2'd0;
              state     <= ISSUE;
            end else begin
              out   <= loc_res;
              err   <= ~is_loc;
              state <= HOLD;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ALU_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          if (unit_done) begin
            out   <= unit_out;
            err   <= 1'b0;
            state <= HOLD;
          end
`ifdef ALU_TIMEOUT_EN
          else if (tmo_cnt == 6'd63) begin
            out   <= 32'hDEADBEEF;
            err   <= 1'b1;
            state <= HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 6'd1;
          end
`endif
        end
        HOLD: begin
          if (out_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
